// File: rtl/pci_pkg.sv
// Shared definitions for the AXI-lite to PCI initiator bridge: command codes,
// AXI response codes and the master FSM state type.
package pci_pkg;

  localparam logic [3:0] PCI_CMD_MEM_RD = 4'h6;
  localparam logic [3:0] PCI_CMD_MEM_WR = 4'h7;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_DATA,
    ST_TERM,
    ST_RESP
  } state_e;

endpackage

// File: rtl/pci_master.sv
// Single-beat AXI-lite slave to PCI core initiator bridge (flat FSM + datapath).
// Optional target-retry support is enabled by defining PCI_MASTER_RETRY_EN.
module pci_master
  import pci_pkg::*;
#(
  parameter int unsigned MAX_RETRY = 16,
  parameter logic [3:0]  CMD_RD    = PCI_CMD_MEM_RD,
  parameter logic [3:0]  CMD_WR    = PCI_CMD_MEM_WR
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        axi_s_awvalid,
  output logic        axi_s_awready,
  input  logic [31:0] axi_s_awaddr,
  input  logic        axi_s_wvalid,
  output logic        axi_s_wready,
  input  logic [31:0] axi_s_wdata,
  input  logic [3:0]  axi_s_wstrb,
  output logic        axi_s_bvalid,
  input  logic        axi_s_bready,
  output logic [1:0]  axi_s_bresp,
  input  logic        axi_s_arvalid,
  output logic        axi_s_arready,
  input  logic [31:0] axi_s_araddr,
  output logic        axi_s_rvalid,
  input  logic        axi_s_rready,
  output logic [31:0] axi_s_rdata,
  output logic [1:0]  axi_s_rresp,
  output logic        REQUEST,
  output logic        REQUESTHOLD,
  output logic        COMPLETE,
  output logic        M_READY,
  output logic        M_WRDN,
  output logic [3:0]  M_CBE,
  output logic [31:0] ADIO_IN,
  input  logic [31:0] ADIO_OUT,
  input  logic        M_DATA_VLD,
  input  logic        M_SRC_EN,
  input  logic        M_DATA,
  input  logic        M_ADDR_N,
  input  logic        TIME_OUT,
  input  logic        STOPQ_N
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic        is_wr_q, is_wr_d;
  logic [1:0]  resp_q, resp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        retry_q, retry_d;

  // Single-beat transfers hold data stable, so the core's source-enable is irrelevant.
  logic unused_ok;
  assign unused_ok = ^{M_SRC_EN, MAX_RETRY[0]};

`ifdef PCI_MASTER_RETRY_EN
  localparam int unsigned CNT_W = $clog2(MAX_RETRY + 1);
  logic [CNT_W-1:0] retry_cnt_q, retry_cnt_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) retry_cnt_q <= '0;
    else     retry_cnt_q <= retry_cnt_d;
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      is_wr_q <= 1'b0;
      resp_q  <= RESP_OKAY;
      rdata_q <= '0;
      retry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      is_wr_q <= is_wr_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    strb_d        = strb_q;
    is_wr_d       = is_wr_q;
    resp_d        = resp_q;
    rdata_d       = rdata_q;
    retry_d       = retry_q;
`ifdef PCI_MASTER_RETRY_EN
    retry_cnt_d   = retry_cnt_q;
`endif
    axi_s_awready = 1'b0;
    axi_s_wready  = 1'b0;
    axi_s_arready = 1'b0;
    axi_s_bvalid  = 1'b0;
    axi_s_rvalid  = 1'b0;
    REQUEST       = 1'b0;
    COMPLETE      = 1'b0;
    M_READY       = 1'b0;
    M_WRDN        = 1'b0;
    M_CBE         = 4'b0000;
    ADIO_IN       = '0;

    unique case (state_q)
      ST_IDLE: begin
        // Readies are gated by RST so every output reads zero while reset is held.
        if (!RST && axi_s_awvalid && axi_s_wvalid) begin
          axi_s_awready = 1'b1;
          axi_s_wready  = 1'b1;
          addr_d        = axi_s_awaddr;
          wdata_d       = axi_s_wdata;
          strb_d        = axi_s_wstrb;
          is_wr_d       = 1'b1;
        end else if (!RST && axi_s_arvalid) begin
          axi_s_arready = 1'b1;
          addr_d        = axi_s_araddr;
          is_wr_d       = 1'b0;
        end
        if (axi_s_awready || axi_s_arready) begin
          resp_d  = RESP_OKAY;
          retry_d = 1'b0;
          state_d = ST_REQ;
`ifdef PCI_MASTER_RETRY_EN
          retry_cnt_d = '0;
`endif
        end
      end
      ST_REQ: begin
        REQUEST = 1'b1;
        state_d = ST_ADDR;
      end
      ST_ADDR: begin
        ADIO_IN = addr_q;
        M_CBE   = is_wr_q ? CMD_WR : CMD_RD;
        M_WRDN  = is_wr_q;
        if (!M_ADDR_N) state_d = ST_DATA;
      end
      ST_DATA: begin
        M_READY  = 1'b1;
        COMPLETE = 1'b1;
        M_WRDN   = is_wr_q;
        M_CBE    = is_wr_q ? ~strb_q : 4'b0000;
        ADIO_IN  = is_wr_q ? wdata_q : '0;
        // Data beat takes priority over a same-cycle master abort.
        if (M_DATA_VLD) begin
          if (!is_wr_q) rdata_d = ADIO_OUT;
          resp_d  = RESP_OKAY;
          state_d = ST_TERM;
        end else if (TIME_OUT) begin
          resp_d  = RESP_DECERR;
          state_d = ST_TERM;
        end else if (!STOPQ_N) begin
          state_d = ST_TERM;
`ifdef PCI_MASTER_RETRY_EN
          if (32'(retry_cnt_q) + 32'd1 >= MAX_RETRY) begin
            resp_d = RESP_SLVERR;
          end else begin
            retry_d     = 1'b1;
            retry_cnt_d = retry_cnt_q + 1'b1;
          end
`else
          resp_d = RESP_SLVERR;
`endif
        end
      end
      ST_TERM: begin
        if (!M_DATA) begin
          retry_d = 1'b0;
          state_d = retry_q ? ST_REQ : ST_RESP;
        end
      end
      ST_RESP: begin
        axi_s_bvalid = is_wr_q;
        axi_s_rvalid = !is_wr_q;
        if ((is_wr_q && axi_s_bready) || (!is_wr_q && axi_s_rready)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign REQUESTHOLD = 1'b0;
  assign axi_s_bresp = resp_q;
  assign axi_s_rresp = resp_q;
  assign axi_s_rdata = rdata_q;

endmodule

// File: tb/tb_pci_master.sv
// Testbench for pci_master: directed vector table, multi-cycle corner sequences,
// and randomized transactions against a behavioural PCI core / response model.
module tb_pci_master;

  localparam int unsigned MAX_RETRY = 16;
  localparam int T_VLD = 0, T_TO = 1, T_BOTH = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        axi_s_awvalid, axi_s_awready;
  logic [31:0] axi_s_awaddr;
  logic        axi_s_wvalid, axi_s_wready;
  logic [31:0] axi_s_wdata;
  logic [3:0]  axi_s_wstrb;
  logic        axi_s_bvalid, axi_s_bready;
  logic [1:0]  axi_s_bresp;
  logic        axi_s_arvalid, axi_s_arready;
  logic [31:0] axi_s_araddr;
  logic        axi_s_rvalid, axi_s_rready;
  logic [31:0] axi_s_rdata;
  logic [1:0]  axi_s_rresp;
  logic        REQUEST, REQUESTHOLD, COMPLETE, M_READY, M_WRDN;
  logic [3:0]  M_CBE;
  logic [31:0] ADIO_IN, ADIO_OUT;
  logic        M_DATA_VLD, M_SRC_EN, M_DATA, M_ADDR_N, TIME_OUT, STOPQ_N;

  int checks = 0;
  int failures = 0;
  int accept_cycles;
  logic [31:0] exp_rdata;

  always #5 CLK = ~CLK;

  pci_master #(.MAX_RETRY(MAX_RETRY), .CMD_RD(4'h6), .CMD_WR(4'h7)) dut (
    .CLK(CLK), .RST(RST),
    .axi_s_awvalid(axi_s_awvalid), .axi_s_awready(axi_s_awready), .axi_s_awaddr(axi_s_awaddr),
    .axi_s_wvalid(axi_s_wvalid), .axi_s_wready(axi_s_wready), .axi_s_wdata(axi_s_wdata),
    .axi_s_wstrb(axi_s_wstrb),
    .axi_s_bvalid(axi_s_bvalid), .axi_s_bready(axi_s_bready), .axi_s_bresp(axi_s_bresp),
    .axi_s_arvalid(axi_s_arvalid), .axi_s_arready(axi_s_arready), .axi_s_araddr(axi_s_araddr),
    .axi_s_rvalid(axi_s_rvalid), .axi_s_rready(axi_s_rready), .axi_s_rdata(axi_s_rdata),
    .axi_s_rresp(axi_s_rresp),
    .REQUEST(REQUEST), .REQUESTHOLD(REQUESTHOLD), .COMPLETE(COMPLETE), .M_READY(M_READY),
    .M_WRDN(M_WRDN), .M_CBE(M_CBE), .ADIO_IN(ADIO_IN), .ADIO_OUT(ADIO_OUT),
    .M_DATA_VLD(M_DATA_VLD), .M_SRC_EN(M_SRC_EN), .M_DATA(M_DATA), .M_ADDR_N(M_ADDR_N),
    .TIME_OUT(TIME_OUT), .STOPQ_N(STOPQ_N)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          nretry;
    int          term;
    int          bdly;
    logic [1:0]  exp_resp;
    int          exp_reqs;
  } vec_t;

  // Response the target's behaviour should produce, from the bus-level rules.
  function automatic logic [1:0] model_resp(input int nretry, input int term);
`ifdef PCI_MASTER_RETRY_EN
    if (nretry >= int'(MAX_RETRY)) return 2'b10;
`else
    if (nretry > 0) return 2'b10;
`endif
    return (term == T_TO) ? 2'b11 : 2'b00;
  endfunction

  function automatic int model_reqs(input int nretry);
`ifdef PCI_MASTER_RETRY_EN
    return (nretry >= int'(MAX_RETRY)) ? int'(MAX_RETRY) : nretry + 1;
`else
    return 1;
`endif
  endfunction

  function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int nretry, input int term,
                              input int bdly, input logic [1:0] resp, input int reqs);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.strb = strb; v.nretry = nretry;
    v.term = term; v.bdly = bdly; v.exp_resp = resp; v.exp_reqs = reqs;
    return v;
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] all_outs();
    return {axi_s_awready, axi_s_wready, axi_s_bvalid, axi_s_bresp, axi_s_arready, axi_s_rvalid,
            axi_s_rresp, axi_s_rdata, REQUEST, REQUESTHOLD, COMPLETE, M_READY, M_WRDN, M_CBE,
            ADIO_IN};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the response handshake.
  task automatic run_txn(input vec_t v, input bit hold_ar);
    int reqs = 0, stops = 0, since = -1, hold = 0, waitc = 0;
    bit accepted = 0, done = 0, seen = 0;
    logic [1:0] exp_resp;
    exp_resp = v.exp_resp;
    if (v.wr) begin
      axi_s_awvalid = 1; axi_s_wvalid = 1;
      axi_s_awaddr = v.addr; axi_s_wdata = v.data; axi_s_wstrb = v.strb;
    end else begin
      axi_s_arvalid = 1; axi_s_araddr = v.addr;
    end
    accept_cycles = 0;
    for (int c = 0; c < 20 && !accepted; c++) begin
      #1;
      if (v.wr ? axi_s_awready : axi_s_arready) begin
        accepted = 1;
        if (v.wr) check("wready_with_awready", {95'd0, axi_s_wready}, 96'd1);
        if (hold_ar) check("arready_blocked_at_accept", {95'd0, axi_s_arready}, 96'd0);
      end else accept_cycles++;
      @(posedge CLK); #1;
    end
    axi_s_awvalid = 0; axi_s_wvalid = 0;
    if (!hold_ar) axi_s_arvalid = 0;
    if (!accepted) begin
      check("accept_timeout", 96'd0, 96'd1);
      return;
    end
    for (int c = 0; c < 400 && !done; c++) begin
      M_ADDR_N = 1; M_DATA_VLD = 0; TIME_OUT = 0; STOPQ_N = 1;
      axi_s_bready = 0; axi_s_rready = 0; ADIO_OUT = ~v.data;
      #1;
      if (hold_ar) check("arready_blocked", {95'd0, axi_s_arready}, 96'd0);
      if (REQUEST) begin
        reqs++; since = 0;
        check("req_idle_bus", {60'd0, M_CBE, ADIO_IN}, 96'd0);
      end else if (since == 0) begin
        check("addr_cbe", {92'd0, M_CBE}, {92'd0, (v.wr ? 4'h7 : 4'h6)});
        check("addr_adio", {64'd0, ADIO_IN}, {64'd0, v.addr});
        check("addr_wrdn_ready", {94'd0, M_WRDN, M_READY}, {94'd0, v.wr, 1'b0});
        M_ADDR_N = 0; since = 1;
      end else if (since == 1) begin
        check("data_ctl", {93'd0, M_READY, COMPLETE, M_WRDN}, {93'd0, 1'b1, 1'b1, v.wr});
        check("data_cbe", {92'd0, M_CBE}, {92'd0, (v.wr ? ~v.strb : 4'b0000)});
        if (v.wr) check("data_adio", {64'd0, ADIO_IN}, {64'd0, v.data});
        since = 2;
      end else if (since == 2) begin
        if (stops < v.nretry) begin
          STOPQ_N = 0; stops++;
        end else begin
          if (v.term != T_TO) begin M_DATA_VLD = 1; ADIO_OUT = v.data; end
          if (v.term != T_VLD) TIME_OUT = 1;
        end
        since = -1; hold = 2;
      end else begin
        if (hold > 0) hold--;
        if (axi_s_bvalid || axi_s_rvalid) begin
          check("valid_kind", {94'd0, axi_s_bvalid, axi_s_rvalid}, {94'd0, v.wr, !v.wr});
          if (!seen) begin
            check("resp", {94'd0, (v.wr ? axi_s_bresp : axi_s_rresp)}, {94'd0, exp_resp});
            if (!v.wr) begin
              if (exp_resp == 2'b00) exp_rdata = v.data;
              check("rdata", {64'd0, axi_s_rdata}, {64'd0, exp_rdata});
            end
          end
          seen = 1;
          if (waitc >= v.bdly) begin
            axi_s_bready = v.wr; axi_s_rready = !v.wr; done = 1;
          end else waitc++;
        end
      end
      M_DATA = (since >= 0) || (hold > 0);
      @(posedge CLK); #1;
    end
    axi_s_bready = 0; axi_s_rready = 0; M_DATA = 0;
    if (!done) check("response_timeout", 96'd0, 96'd1);
    check("request_pulses", 96'(reqs), 96'(v.exp_reqs));
    check("valid_dropped", {94'd0, axi_s_bvalid, axi_s_rvalid}, 96'd0);
  endtask

  vec_t tbl[8];

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    RST = 1;
    axi_s_awvalid = 0; axi_s_awaddr = 0; axi_s_wvalid = 0; axi_s_wdata = 0; axi_s_wstrb = 0;
    axi_s_bready = 0; axi_s_arvalid = 0; axi_s_araddr = 0; axi_s_rready = 0;
    ADIO_OUT = 0; M_DATA_VLD = 0; M_SRC_EN = 0; M_DATA = 0; M_ADDR_N = 1; TIME_OUT = 0;
    STOPQ_N = 1;
    exp_rdata = 32'd0;

    tbl[0] = mk(1, 32'h1000_0010, 32'hA5A5_5A5A, 4'b0011, 0, T_VLD, 0, 2'b00, 1);
    tbl[1] = mk(0, 32'h2000_0000, 32'hDEAD_BEEF, 4'b0000, 0, T_VLD, 1, 2'b00, 1);
    tbl[2] = mk(1, 32'h1000_0020, 32'h1234_5678, 4'b1111, 0, T_TO, 0, 2'b11, 1);
    tbl[3] = mk(1, 32'h1000_0030, 32'h0BAD_F00D, 4'b0101, 0, T_BOTH, 2, 2'b00, 1);
    tbl[4] = mk(0, 32'h2000_0040, 32'h5555_AAAA, 4'b0000, 0, T_TO, 0, 2'b11, 1);
    tbl[5] = mk(1, 32'h1000_0050, 32'hCAFE_0001, 4'b1000, 3, T_VLD, 0, model_resp(3, T_VLD), model_reqs(3));
    tbl[6] = mk(1, 32'h1000_0060, 32'hCAFE_0002, 4'b0110, 16, T_VLD, 0, model_resp(16, T_VLD), model_reqs(16));
    tbl[7] = mk(0, 32'h2000_0070, 32'hCAFE_0003, 4'b0000, 1, T_VLD, 0, model_resp(1, T_VLD), model_reqs(1));

    repeat (3) @(posedge CLK);
    #1;
    check("reset_outputs", all_outs(), 96'd0);
    RST = 0;
    @(posedge CLK); #1;

    foreach (tbl[i]) run_txn(tbl[i], 1'b0);

    // Write, read and address valids together: write first, read blocked through a stalled bready.
    axi_s_arvalid = 1; axi_s_araddr = 32'h3000_0004;
    run_txn(mk(1, 32'h1000_0100, 32'h0F0F_F0F0, 4'b1001, 0, T_VLD, 10, 2'b00, 1), 1'b1);
    run_txn(mk(0, 32'h3000_0004, 32'h7777_1111, 4'b0000, 0, T_VLD, 0, 2'b00, 1), 1'b0);
    check("read_accept_after_write", 96'(accept_cycles), 96'd0);

    for (int n = 0; n < 30; n++) begin
      v.wr = $urandom_range(0, 1) == 1;
      v.addr = $urandom; v.data = $urandom; v.strb = 4'($urandom);
      v.nretry = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      v.term = int'($urandom_range(0, 2));
      v.bdly = int'($urandom_range(0, 3));
      v.exp_resp = model_resp(v.nretry, v.term);
      v.exp_reqs = model_reqs(v.nretry);
      run_txn(v, 1'b0);
    end

    // Reset during the data phase abandons the write with no response.
    axi_s_awvalid = 1; axi_s_wvalid = 1; axi_s_awaddr = 32'h1000_0200;
    axi_s_wdata = 32'h1357_9BDF; axi_s_wstrb = 4'hF; M_DATA = 1;
    for (int c = 0; c < 20 && !M_READY; c++) begin
      #1;
      if (axi_s_awready) M_ADDR_N = 0;
      @(posedge CLK); #1;
      axi_s_awvalid = 0; axi_s_wvalid = 0;
    end
    check("reached_data_phase", {95'd0, M_READY}, 96'd1);
    M_ADDR_N = 1;
    RST = 1;
    #1;
    check("async_reset_outputs", all_outs(), 96'd0);
    @(posedge CLK); #1;
    check("reset_outputs_edge", all_outs(), 96'd0);
    RST = 0; M_DATA = 0; axi_s_bready = 1;
    for (int c = 0; c < 6; c++) begin
      @(posedge CLK); #1;
      check("no_bvalid_after_reset", {94'd0, axi_s_bvalid, REQUEST}, 96'd0);
    end
    axi_s_bready = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
